// File: rtl/xgriscv_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// xgriscv_mem_arbiter_pkg
//   Shared types and constants for the unified-memory arbiter.
//   Contents:
//     arb_state_e  FSM states, keeping the legacy 2-bit codes
//                  (IDLE=00, RD_WAIT=01, WR_DONE=10)
//     arb_own_e    owner of the access in flight (I = fetch, D = MEM stage)
//     AMP_WORD     byte-enable pattern for full-word reads
//     lat_preset() converts a read latency into the RD_WAIT counter preset
// ----------------------------------------------------------------------------
package xgriscv_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_RD_WAIT = 2'b01,
      ARB_WR_DONE = 2'b10
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_I = 1'b0,
      ARB_OWN_D = 1'b1
   } arb_own_e;

   localparam logic [3:0] AMP_WORD = 4'b1111;

   // Latency counter width: RD_LAT is limited to 1..7.
   localparam int unsigned LAT_CNT_W = 3;

   // RD_WAIT is entered with RD_LAT-1 and completes when the counter reaches 0.
   function automatic logic [LAT_CNT_W-1:0] lat_preset(input int unsigned rd_lat);
      return LAT_CNT_W'(rd_lat - 1);
   endfunction

endpackage

// File: rtl/xgriscv_mem_arbiter_sat_counter.sv
// ----------------------------------------------------------------------------
// arb_sat_counter
//   Saturating event counter used for the arbiter performance statistics.
//   Ports:
//     clk  in   clock, rising edge
//     en   in   count this cycle
//     clr  in   synchronous clear (takes priority over en)
//     cnt  out  current count, sticks at all-ones
// ----------------------------------------------------------------------------
module arb_sat_counter
   import xgriscv_mem_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/xgriscv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// xgriscv_mem_arbiter
//   Shares one single-port unified memory between instruction fetch (I) and
//   the MEM stage (D). One access in flight; D wins ties. Reads wait a fixed
//   RD_LAT cycles, stores complete in the cycle after the grant.
//   Optional macro: XGRISCV_ARB_PERF_EN adds saturating perf counters
//   (perf_conflict, perf_stall_i, perf_stall_d, width CNT_W).
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     i_req/i_addr/i_kill            fetch request, address, redirect cancel
//     i_valid/i_rdata                fetch completion pulse and word
//     d_req/d_we/d_amp/d_addr/d_wdata  load/store request
//     d_valid/d_rdata                data completion pulse and load word
//     stall_i, stall_d               hold F / M until their access completes
//     mem_en/mem_we/mem_amp/mem_addr/mem_wdata  memory command, mem_en is
//                                    a one-cycle strobe per access
//     mem_rdata                      read data, RD_LAT cycles after mem_en
// ----------------------------------------------------------------------------
module xgriscv_mem_arbiter
   import xgriscv_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
`ifdef XGRISCV_ARB_PERF_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_kill,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_amp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_i,
   output logic              stall_d,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_amp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef XGRISCV_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_conflict,
   output logic [CNT_W-1:0]  perf_stall_i,
   output logic [CNT_W-1:0]  perf_stall_d
`endif
);

   localparam logic [LAT_CNT_W-1:0] LAT_PRESET = lat_preset(RD_LAT);

   arb_state_e           state_q, state_d;
   arb_own_e             own_q, own_d;
   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 kill_q, kill_d;
   logic                 rst_q;
   logic [DATA_W-1:0]    i_rdata_q, d_rdata_q;

   logic blk;
   logic grant_d;
   logic grant_i;
   logic rd_done;

   // Outputs are forced low in the reset cycle and in the cycle after it;
   // rst_q covers the second one so requests are first sampled afterwards.
   assign blk = reset | rst_q;

   always_comb begin
      grant_d = (state_q == ARB_IDLE) && !blk && d_req;
      grant_i = (state_q == ARB_IDLE) && !blk && !d_req && i_req && !i_kill;
      rd_done = (state_q == ARB_RD_WAIT) && (cnt_q == '0) && !blk;
   end

   // A killed fetch still runs to completion in the memory; its response is
   // dropped, including when the kill arrives in the completion cycle itself.
   always_comb begin
      i_valid = rd_done && (own_q == ARB_OWN_I) && !kill_q && !i_kill;
      d_valid = !blk && ((state_q == ARB_WR_DONE) ||
                         (rd_done && (own_q == ARB_OWN_D)));
      i_rdata = blk ? '0 : (i_valid ? mem_rdata : i_rdata_q);
      d_rdata = blk ? '0 : ((rd_done && (own_q == ARB_OWN_D)) ? mem_rdata : d_rdata_q);
      stall_i = !blk && i_req && !i_valid;
      stall_d = !blk && d_req && !d_valid;
   end

   always_comb begin
      mem_en    = grant_d || grant_i;
      mem_we    = grant_d && d_we;
      mem_amp   = mem_we ? d_amp : (mem_en ? AMP_WORD : 4'b0000);
      mem_addr  = grant_d ? d_addr : (grant_i ? i_addr : '0);
      mem_wdata = mem_we ? d_wdata : '0;
   end

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_d) begin
               own_d  = ARB_OWN_D;
               kill_d = 1'b0;
               if (d_we) begin
                  state_d = ARB_WR_DONE;
               end else begin
                  state_d = ARB_RD_WAIT;
                  cnt_d   = LAT_PRESET;
               end
            end else if (grant_i) begin
               own_d   = ARB_OWN_I;
               kill_d  = 1'b0;
               state_d = ARB_RD_WAIT;
               cnt_d   = LAT_PRESET;
            end
         end
         ARB_RD_WAIT: begin
            if ((own_q == ARB_OWN_I) && i_kill) begin
               kill_d = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = ARB_IDLE;
            end else begin
               cnt_d = cnt_q - LAT_CNT_W'(1);
            end
         end
         ARB_WR_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB_IDLE;
         own_q     <= ARB_OWN_I;
         cnt_q     <= '0;
         kill_q    <= 1'b0;
         rst_q     <= 1'b1;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         rst_q   <= 1'b0;
         if (i_valid) begin
            i_rdata_q <= mem_rdata;
         end
         if (rd_done && (own_q == ARB_OWN_D)) begin
            d_rdata_q <= mem_rdata;
         end
      end
   end

   // Requesters must hold their command stable while it is in flight.
   a_d_stable: assert property (@(posedge clk) disable iff (reset)
      ((state_q != ARB_IDLE) && (own_q == ARB_OWN_D)) |->
         ($stable(d_addr) && $stable(d_we) && $stable(d_amp) && $stable(d_wdata)));

   a_i_stable: assert property (@(posedge clk) disable iff (reset)
      ((state_q != ARB_IDLE) && (own_q == ARB_OWN_I) && !kill_q && !i_kill) |->
         $stable(i_addr));

`ifdef XGRISCV_ARB_PERF_EN
   logic conflict_ev;
   assign conflict_ev = (state_q == ARB_IDLE) && !blk && d_req && i_req;

   arb_sat_counter #(.CNT_W(CNT_W)) u_perf_conflict (
      .clk (clk),
      .en  (conflict_ev),
      .clr (reset),
      .cnt (perf_conflict)
   );

   arb_sat_counter #(.CNT_W(CNT_W)) u_perf_stall_i (
      .clk (clk),
      .en  (stall_i),
      .clr (reset),
      .cnt (perf_stall_i)
   );

   arb_sat_counter #(.CNT_W(CNT_W)) u_perf_stall_d (
      .clk (clk),
      .en  (stall_d),
      .clr (reset),
      .cnt (perf_stall_d)
   );
`endif

endmodule
